// File: rtl/addsub_pkg.sv
// Package shared by the pipelined add/subtract datapath.
// Contents:
//   WIDTH_DEFAULT / STAGES_DEFAULT : default operand width and pipeline depth
//   seg_width()                    : bits handled by each pipeline segment
//   flags_t                        : ALU flag bundle registered alongside the sum
package addsub_pkg;

  localparam int unsigned WIDTH_DEFAULT  = 32;
  localparam int unsigned STAGES_DEFAULT = 4;

  function automatic int unsigned seg_width(input int unsigned width,
                                            input int unsigned stages);
    return width / stages;
  endfunction

  typedef struct packed {
    logic cout;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;

endpackage

// File: rtl/addsub_segment.sv
// Combinational ripple-carry adder slice, one per pipeline stage.
// full_adder : single-bit cell (a, b, ci) -> (s, co)
// addsub_segment ports:
//   a, b  [SEG]  operand bits of this segment (b already conditionally inverted)
//   cin          carry into the segment's LSB
//   sum   [SEG]  segment result
//   cout         carry out of the segment's MSB
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module addsub_segment
  import addsub_pkg::*;
#(
  parameter int unsigned SEG = seg_width(WIDTH_DEFAULT, STAGES_DEFAULT)
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  // Each bit keeps its own carry signal so the chain is a set of distinct
  // nets rather than one vector that feeds back on itself.
  for (genvar i = 0; i < SEG; i++) begin : g_bit
    logic ci;
    logic co;

    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_chain
      assign ci = g_bit[i-1].co;
    end

    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (ci),
      .s  (sum[i]),
      .co (co)
    );
  end

  assign cout = g_bit[SEG-1].co;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready handshake.
// The carry chain is cut into STAGES segments; stage k adds bits
// [k*SEG +: SEG] with the carry registered by stage k-1. Operand bits of
// later segments ride along in skew registers; finished low segments ride
// along in de-skew registers so each result leaves fully aligned.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready input handshake (in_ready is combinational)
//   a, b, cin, sub      operands; sub inverts b, cin is used as given
//   out_valid/out_ready output handshake
//   sum, cout           result and carry out of bit WIDTH-1
//   overflow, zero,     signed overflow, sum == 0, sum[WIDTH-1]
//   negative
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEFAULT,
  parameter int unsigned STAGES = STAGES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned SEG = seg_width(WIDTH, STAGES);
  localparam int unsigned MSB = WIDTH - 1;

  logic             advance;
  logic [WIDTH-1:0] b_eff;

  // Inputs seen by each stage: stage 0 from the ports, stage k from
  // pipeline register k-1.
  logic [WIDTH-1:0] stg_a [STAGES];
  logic [WIDTH-1:0] stg_b [STAGES];
  logic [WIDTH-1:0] stg_s [STAGES];
  logic             stg_c [STAGES];
  logic             stg_v [STAGES];

  // Per-stage combinational results.
  logic [WIDTH-1:0] nxt_s    [STAGES];
  logic             seg_cout [STAGES];

  logic [WIDTH-1:0] final_sum;
  flags_t           flags_nxt;

  logic [WIDTH-1:0] sum_r;
  flags_t           flags_r;
  logic             valid_r;

  // Whole pipeline moves together; it only holds when a result is waiting
  // at the output and the consumer refuses it.
  assign advance  = !valid_r || out_ready;
  assign in_ready = advance && !rst;

  assign b_eff    = sub ? ~b : b;

  assign stg_a[0] = a;
  assign stg_b[0] = b_eff;
  assign stg_s[0] = '0;
  assign stg_c[0] = cin;
  assign stg_v[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0]   seg_sum;
    logic [WIDTH-1:0] spliced;

    addsub_segment #(
      .SEG (SEG)
    ) u_seg (
      .a    (stg_a[k][k*SEG +: SEG]),
      .b    (stg_b[k][k*SEG +: SEG]),
      .cin  (stg_c[k]),
      .sum  (seg_sum),
      .cout (seg_cout[k])
    );

    // Lower segments arrive already finished; drop this segment's bits in.
    always_comb begin
      spliced                 = stg_s[k];
      spliced[k*SEG +: SEG]   = seg_sum;
    end

    assign nxt_s[k] = spliced;
  end

  if (STAGES > 1) begin : g_pipe
    logic [WIDTH-1:0] r_a [STAGES-1];
    logic [WIDTH-1:0] r_b [STAGES-1];
    logic [WIDTH-1:0] r_s [STAGES-1];
    logic             r_c [STAGES-1];
    logic             r_v [STAGES-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned j = 0; j < STAGES - 1; j++) begin
          r_v[j] <= 1'b0;
        end
      end else if (advance) begin
        for (int unsigned j = 0; j < STAGES - 1; j++) begin
          r_v[j] <= stg_v[j];
          r_a[j] <= stg_a[j];
          r_b[j] <= stg_b[j];
          r_s[j] <= nxt_s[j];
          r_c[j] <= seg_cout[j];
        end
      end
    end

    for (genvar k = 1; k < STAGES; k++) begin : g_link
      assign stg_a[k] = r_a[k-1];
      assign stg_b[k] = r_b[k-1];
      assign stg_s[k] = r_s[k-1];
      assign stg_c[k] = r_c[k-1];
      assign stg_v[k] = r_v[k-1];
    end
  end

  // Flags come from the last stage, which holds the top segment's operands.
  always_comb begin
    final_sum          = nxt_s[STAGES-1];
    flags_nxt.cout     = seg_cout[STAGES-1];
    flags_nxt.overflow = (stg_a[STAGES-1][MSB] == stg_b[STAGES-1][MSB]) &&
                         (final_sum[MSB] != stg_a[STAGES-1][MSB]);
    flags_nxt.zero     = (final_sum == '0);
    flags_nxt.negative = final_sum[MSB];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      sum_r   <= '0;
      flags_r <= '0;
    end else if (advance) begin
      valid_r <= stg_v[STAGES-1];
      sum_r   <= final_sum;
      flags_r <= flags_nxt;
    end
  end

  assign out_valid = valid_r;
  assign sum       = sum_r;
  assign cout      = flags_r.cout;
  assign overflow  = flags_r.overflow;
  assign zero      = flags_r.zero;
  assign negative  = flags_r.negative;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: three configurations
// (32/4, 32/1, 64/8) share one stimulus; the 32/4 instance also gets a
// randomized stream against a reference model and scoreboard.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        cin;
  logic        sub;
  logic        out_ready;
  logic [63:0] a;
  logic [63:0] b;

  logic        rdy4, ov4, co4, of4, z4, n4;
  logic [31:0] s4;
  logic        rdy1, ov1, co1, of1, z1, n1;
  logic [31:0] s1;
  logic        rdy8, ov8, co8, of8, z8, n8;
  logic [63:0] s8;

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
    .out_valid(ov4), .out_ready(out_ready), .sum(s4), .cout(co4),
    .overflow(of4), .zero(z4), .negative(n4));

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .a(a[31:0]), .b(b[31:0]), .cin(cin), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .sum(s1), .cout(co1),
    .overflow(of1), .zero(z1), .negative(n1));

  pipelined_addsub #(.WIDTH(64), .STAGES(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov8), .out_ready(out_ready), .sum(s8), .cout(co8),
    .overflow(of8), .zero(z8), .negative(n8));

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- reference model (32-bit) ----------------
  typedef struct {
    logic [31:0] sum;
    logic [3:0]  flags; // {cout, overflow, zero, negative}
  } res_t;

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic s);
    res_t        r;
    logic [31:0] eb;
    logic [32:0] full;
    longint      st;
    eb     = s ? ~y : y;
    full   = 33'(x) + 33'(eb) + 33'(ci);
    st     = longint'($signed(x)) + longint'($signed(eb)) + longint'(ci);
    r.sum  = full[31:0];
    r.flags = {full[32], (st > 64'sd2147483647) || (st < -64'sd2147483648),
               (full[31:0] == 32'd0), full[31]};
    return r;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    int          width;
    logic [63:0] va;
    logic [63:0] vb;
    logic        vcin;
    logic        vsub;
    logic [63:0] esum;
    logic [3:0]  eflags; // {cout, overflow, zero, negative}
  } vec_t;

  vec_t vecs [10];

  // ---------------- stream scoreboard state ----------------
  res_t        exp_q [$];
  logic        hold        = 1'b0;
  logic        stalled     = 1'b0;
  logic [31:0] snap_sum;
  logic [3:0]  snap_flags;
  int          popped      = 0;

  // One handshake cycle on dut4: drive at negedge, sample 1 time unit later.
  task automatic cycle(input logic v, input logic rdy);
    res_t e;
    @(negedge clk);
    if (!hold) begin
      in_valid = v;
      if (v) begin
        a   = {32'd0, $urandom};
        b   = {32'd0, $urandom};
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
      end
    end
    out_ready = rdy;
    #1;
    check("in_ready_rule", rdy4, !ov4 || out_ready);
    if (stalled) begin
      check("stall_valid", ov4, 1'b1);
      check("stall_sum", s4, snap_sum);
      check("stall_flags", {co4, of4, z4, n4}, snap_flags);
    end
    stalled    = ov4 && !out_ready;
    snap_sum   = s4;
    snap_flags = {co4, of4, z4, n4};
    if (ov4 && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        popped++;
        check("stream_sum", s4, e.sum);
        check("stream_flags", {co4, of4, z4, n4}, e.flags);
      end
    end
    if (in_valid && rdy4) begin
      exp_q.push_back(model(a[31:0], b[31:0], cin, sub));
      hold = 1'b0;
    end else begin
      hold = in_valid;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          lat4, lat1, lat8;
    logic [31:0] g4, g1;
    logic [63:0] g8;
    logic [3:0]  f4, f1, f8;
    lat4 = 0; lat1 = 0; lat8 = 0;
    g4 = '0; g1 = '0; g8 = '0; f4 = '0; f1 = '0; f8 = '0;
    @(negedge clk);
    a = v.va; b = v.vb; cin = v.vcin; sub = v.vsub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("vec_in_ready", rdy4 && rdy1 && rdy8, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      if (ov4 && lat4 == 0) begin lat4 = n; g4 = s4; f4 = {co4, of4, z4, n4}; end
      if (ov1 && lat1 == 0) begin lat1 = n; g1 = s1; f1 = {co1, of1, z1, n1}; end
      if (ov8 && lat8 == 0) begin lat8 = n; g8 = s8; f8 = {co8, of8, z8, n8}; end
      @(posedge clk);
      #1;
    end
    if (v.width == 32) begin
      check("vec32_s4_latency", 64'(lat4), 64'd4);
      check("vec32_s4_sum", g4, v.esum);
      check("vec32_s4_flags", f4, v.eflags);
      check("vec32_s1_latency", 64'(lat1), 64'd1);
      check("vec32_s1_sum", g1, v.esum);
      check("vec32_s1_flags", f1, v.eflags);
    end else begin
      check("vec64_s8_latency", 64'(lat8), 64'd8);
      check("vec64_s8_sum", g8, v.esum);
      check("vec64_s8_flags", f8, v.eflags);
    end
  endtask

  initial begin
    int outs_after_reset;

    vecs[0] = '{32, 64'h1, 64'hFFFF_FFFF, 1'b0, 1'b0, 64'h0, 4'b1010};
    vecs[1] = '{32, 64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000, 4'b0101};
    vecs[2] = '{32, 64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFE, 4'b0001};
    vecs[3] = '{32, 64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 4'b1000};
    vecs[4] = '{32, 64'h8000_0000, 64'h1, 1'b1, 1'b1, 64'h7FFF_FFFF, 4'b1100};
    vecs[5] = '{32, 64'hFFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 4'b1010};
    vecs[6] = '{64, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h0, 4'b1010};
    vecs[7] = '{64, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 4'b0101};
    vecs[8] = '{64, 64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0001};
    vecs[9] = '{64, 64'h7, 64'h5, 1'b1, 1'b1, 64'h2, 4'b1000};

    // ---------------- reset state ----------------
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_in_ready", rdy4, 1'b0);
    check("reset_out_valid", {ov4, ov1, ov8}, 3'b000);
    check("reset_sum4", s4, 32'd0);
    check("reset_sum8", s8, 64'd0);
    check("reset_flags4", {co4, of4, z4, n4}, 4'b0000);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", {rdy4, rdy1, rdy8}, 3'b111);

    // ---------------- directed table ----------------
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // ---------------- back-to-back stream of 10 ----------------
    popped = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 4; i++)  cycle(1'b0, 1'b1);
    check("stream10_count", 64'(popped), 64'd10);

    // ---------------- backpressure mid-stream ----------------
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0);
      check("stall_in_ready", rdy4, 1'b0);
    end
    for (int i = 0; i < 4; i++)  cycle(1'b1, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1);
    check("backpressure_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- randomized valid/ready ----------------
    for (int i = 0; i < 300; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1);
    check("random_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- reset with beats in flight ----------------
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check("midreset_in_ready", rdy4, 1'b0);
    @(posedge clk);
    #1;
    check("midreset_out_valid", {ov4, ov1, ov8}, 3'b000);
    check("midreset_sum4", s4, 32'd0);
    check("midreset_flags4", {co4, of4, z4, n4}, 4'b0000);
    exp_q.delete();
    hold = 1'b0; stalled = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    outs_after_reset = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1);
      if (ov4) outs_after_reset++;
    end
    check("no_stale_after_reset", 64'(outs_after_reset), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
